gen_escritura_rtc: RTL

GEN_ESCRITURA_RTC -- requirements
Module: gen_escritura_rtc

---
 rtl/gen_escritura_rtc.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gen_escritura_rtc.sv
// Write-cycle generator for a multiplexed-bus RTC: each write is an address phase and a
// data phase, each with setup, strobe and hold timing, followed by a one-cycle Final_WR.
module gen_escritura_rtc #(
    parameter int T_SU = 2,
    parameter int T_W  = 4,
    parameter int T_H  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ctrl_I,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       Final_WR,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, A_SU, A_WR, A_H, D_SU, D_WR, D_H, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] addr;
        logic [7:0] data;
    } step_t;

    // Steps 0, 9 and 12-15 are not write steps.
    function automatic step_t lookup(input logic [3:0] s);
        case (s)
            4'd1:    lookup = '{1'b1, 8'h02, 8'h10};
            4'd2:    lookup = '{1'b1, 8'h02, 8'h00};
            4'd3:    lookup = '{1'b1, 8'h10, 8'hD2};
            4'd4:    lookup = '{1'b1, 8'h00, 8'h04};
            4'd5:    lookup = '{1'b1, 8'h01, 8'h00};
            4'd6:    lookup = '{1'b1, 8'h75, 8'h08};
            4'd7:    lookup = '{1'b1, 8'hF2, 8'h00};
            4'd8:    lookup = '{1'b1, 8'hF1, 8'h00};
            4'd10:   lookup = '{1'b1, 8'hF3, 8'h00};
            4'd11:   lookup = '{1'b1, 8'h02, 8'h00};
            default: lookup = '{1'b0, 8'h00, 8'h00};
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] last_step_q, last_step_d;
    logic [3:0] step_q, step_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    step_t      entry;

    logic       cs_n_q, cs_n_d;
    logic       wr_n_q, wr_n_d;
    logic       ad_n_q, ad_n_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       final_q, final_d;
    logic       busy_q, busy_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_step_d = last_step_q;
        step_d      = step_q;
        addr_d      = addr_q;
        data_d      = data_q;
        entry       = lookup(ctrl_I);

        case (state_q)
            IDLE: begin
                if (ctrl_I == 4'd0) begin
                    last_step_d = 4'd0;
                end else if (entry.valid && ctrl_I != last_step_q) begin
                    state_d = A_SU;
                    cnt_d   = 4'(T_SU - 1);
                    step_d  = ctrl_I;
                    addr_d  = entry.addr;
                    data_d  = entry.data;
                end
            end
            A_SU: if (cnt_q == 4'd0) begin state_d = A_WR; cnt_d = 4'(T_W - 1);  end else cnt_d = cnt_q - 4'd1;
            A_WR: if (cnt_q == 4'd0) begin state_d = A_H;  cnt_d = 4'(T_H - 1);  end else cnt_d = cnt_q - 4'd1;
            A_H:  if (cnt_q == 4'd0) begin state_d = D_SU; cnt_d = 4'(T_SU - 1); end else cnt_d = cnt_q - 4'd1;
            D_SU: if (cnt_q == 4'd0) begin state_d = D_WR; cnt_d = 4'(T_W - 1);  end else cnt_d = cnt_q - 4'd1;
            D_WR: if (cnt_q == 4'd0) begin state_d = D_H;  cnt_d = 4'(T_H - 1);  end else cnt_d = cnt_q - 4'd1;
            D_H: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    cnt_d       = 4'd0;
                    last_step_d = step_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: begin state_d = IDLE; cnt_d = 4'd0; end
        endcase

        // Outputs are decoded from the next state and registered, so they are glitch-free
        // and appear in the same cycle the state is entered.
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_n_d   = 1'b0;
        ad_out_d = 8'h00;
        ad_oe_d  = 1'b0;
        final_d  = 1'b0;
        busy_d   = (state_d != IDLE);
        case (state_d)
            A_SU, A_WR, A_H: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                wr_n_d   = (state_d != A_WR);
            end
            D_SU, D_WR, D_H: begin
                cs_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_n_d   = 1'b1;
                ad_out_d = data_d;
                wr_n_d   = (state_d != D_WR);
            end
            DONE:    final_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the reset clears every register, including the latched step data, so an
        // aborted write leaves nothing behind that could be mistaken for a served step.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_step_q <= 4'd0;
            step_q      <= 4'd0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ad_n_q      <= 1'b0;
            ad_out_q    <= 8'h00;
            ad_oe_q     <= 1'b0;
            final_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together from old values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_step_q <= last_step_d;
            step_q      <= step_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            ad_n_q      <= ad_n_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            final_q     <= final_d;
            busy_q      <= busy_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign rd_n     = 1'b1;
    assign wr_n     = wr_n_q;
    assign ad_n     = ad_n_q;
    assign ad_out   = ad_out_q;
    assign ad_oe    = ad_oe_q;
    assign Final_WR = final_q;
    assign busy     = busy_q;

endmodule
